petra_link: RTL and testbench
=============================

PETRA_LINK -- requirements
Module: petra_link

Interface
REQ-001 Parameter MSG_WIDTH, default 8: data bits per frame, ≥1.
REQ-002 Parameter BIT_CLOCKS, default 4: clock cycles per line bit, even, ≥2.
REQ-003 Parameter FIFO_DEPTH, default 4: TX FIFO entries, power of 2, ≥2.
REQ-004 Parameter PARITY_EN, default 1: 1 inserts an even-parity bit, 0 omits it.
REQ-005 clock  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 send_message  input  1  one-cycle write strobe; pushes data_in into the TX FIFO.
REQ-008 data_in  input  MSG_WIDTH  word to transmit.
REQ-009 data_out  output  MSG_WIDTH  last correctly received word.
REQ-010 irq_tx  output  1  one-cycle pulse at the end of each transmitted frame.
REQ-011 irq_rx  output  1  one-cycle pulse when data_out is updated.
REQ-012 rx_error  output  1  one-cycle pulse on a parity or stop error.
REQ-013 tx_full  output  1  TX FIFO holds FIFO_DEPTH words.
REQ-014 tx_overflow  output  1  sticky: a write was dropped; cleared only by reset.
REQ-015 led_in  input  1  optical receive line, asynchronous to clock.
REQ-016 led_out  output  1  optical transmit line, registered.

Function
REQ-017 Frame format, each bit held BIT_CLOCKS cycles: idle 0; start 1; data LSB first; parity (if PARITY_EN) making the count of 1s in data+parity even; stop 0.
REQ-018 Frame length F = (MSG_WIDTH + PARITY_EN + 2) * BIT_CLOCKS cycles; default F = 44.
REQ-019 Write with tx_full=0 is accepted; write with tx_full=1 is dropped and sets tx_overflow, even if a pop occurs in the same cycle.
REQ-020 FIFO order is strict FIFO; pointers wrap modulo FIFO_DEPTH; tx_full is derived from registered occupancy.
REQ-021 TX FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-022 IDLE->START on the edge after the FIFO becomes non-empty; the head word is popped on that edge; led_out=1 from that edge.
REQ-023 A word written to an empty FIFO with TX in IDLE starts on the next edge: 1 cycle latency to led_out rising.
REQ-024 STOP->START directly if the FIFO is non-empty, else STOP->IDLE; irq_tx pulses in the last cycle of STOP in both cases.
REQ-025 led_in passes through a 2-flop synchroniser before any use.
REQ-026 RX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-027 RX IDLE->START on a synchronised 0->1 edge.
REQ-028 RX samples the start bit at BIT_CLOCKS/2 cycles; if it is 0, RX returns to IDLE with no pulse (glitch reject); otherwise each later bit is sampled BIT_CLOCKS cycles after the previous sample.
REQ-029 After the stop sample: parity OK and stop=0 -> data_out loaded and irq_rx pulses in the same cycle; otherwise rx_error pulses and data_out holds.
REQ-030 irq_rx and rx_error are never asserted together.
REQ-031 TX and RX are fully independent; an instance does not receive its own frames unless led_out is looped back to led_in.

Reset
REQ-032 While reset=1, asynchronously: led_out=0, data_out=0, irq_tx/irq_rx/rx_error/tx_overflow=0, tx_full=0, FIFO empty, both FSMs IDLE, synchroniser 0.
REQ-033 Reset mid-frame aborts it: no irq_tx for the aborted frame, queued words are discarded.
REQ-034 Operation resumes on the first edge after reset deasserts.

Verification (two instances A, B; A.led_out->B.led_in and B.led_out->A.led_in; defaults unless stated)
REQ-035 Write 8'h50 to A after reset -> A.led_out=1 one cycle later; A.irq_tx pulse 44 cycles after the frame starts; B.irq_rx pulse with B.data_out=8'h50; B.rx_error=0.
REQ-036 Six back-to-back writes 8'h01..8'h06 to A -> tx_full=1 after the 5th write; 8'h06 dropped; tx_overflow=1; B receives 01..05 in order, back to back, five irq_rx pulses.
REQ-037 Bench-driven B.led_in frame carrying 8'hA5 with parity bit 1 -> B.rx_error pulses once; no irq_rx; B.data_out keeps its previous value.
REQ-038 B.led_in high for 1 cycle only -> no irq_rx, no rx_error; B RX back in IDLE.
REQ-039 Reset asserted 20 cycles into A's frame of 8'h3C -> led_out=0 immediately; no irq_tx. After release, wait ≥ F cycles, write 8'h3C -> B.data_out=8'h3C.
REQ-040 PARITY_EN=0, MSG_WIDTH=12, BIT_CLOCKS=2 -> frame 28 cycles; 12'hABC delivered with irq_rx.

Source files
------------

// File: rtl/petra_link_if.sv
// Host-side bus of a petra_link optical transceiver: TX write strobe/data, RX word and status.
interface petra_link_if #(
    parameter int unsigned MSG_WIDTH = 8
);
    logic                 send_message;
    logic [MSG_WIDTH-1:0] data_in;
    logic [MSG_WIDTH-1:0] data_out;
    logic                 irq_tx;
    logic                 irq_rx;
    logic                 rx_error;
    logic                 tx_full;
    logic                 tx_overflow;

    modport master (
        output send_message, data_in,
        input  data_out, irq_tx, irq_rx, rx_error, tx_full, tx_overflow
    );

    modport slave (
        input  send_message, data_in,
        output data_out, irq_tx, irq_rx, rx_error, tx_full, tx_overflow
    );
endinterface

// File: rtl/petra_link.sv
// Optical serial link: TX FIFO feeding a framed on-off-keyed transmitter, and an
// independent oversampling receiver with even-parity and stop-bit checking.
module petra_link #(
    parameter int unsigned MSG_WIDTH  = 8,
    parameter int unsigned BIT_CLOCKS = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          PARITY_EN  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    petra_link_if.slave bus,
    input  logic        led_in,
    output logic        led_out
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OccW = PtrW + 1;
    localparam int unsigned CntW = $clog2(BIT_CLOCKS);
    localparam int unsigned BitW = (MSG_WIDTH > 1) ? $clog2(MSG_WIDTH) : 1;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    // ---------------- TX FIFO ----------------
    logic [MSG_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]      count_q;
    logic                 full, nonempty, push, pop, overflow_q;

    assign full     = (count_q == OccW'(FIFO_DEPTH));
    assign nonempty = (count_q != '0);
    assign push     = bus.send_message && !full;

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.data_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + OccW'(1);
            else if (pop && !push) count_q <= count_q - OccW'(1);
            // Full is judged on registered occupancy, so a same-cycle pop does not rescue a write.
            if (bus.send_message && full) overflow_q <= 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [BitW-1:0]      tx_bit_q, tx_bit_d;
    logic [MSG_WIDTH-1:0] tx_word_q, tx_word_d;
    logic                 led_q, led_d, tx_done, irq_tx;

    assign tx_done = (tx_cnt_q == CntW'(BIT_CLOCKS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_word_q  <= '0;
            led_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_word_q  <= tx_word_d;
            led_q      <= led_d;
        end
    end

    // led_d is the line level of the state being entered, so led_out stays a plain register.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CntW'(1);
        tx_bit_d   = tx_bit_q;
        tx_word_d  = tx_word_q;
        led_d      = led_q;
        pop        = 1'b0;
        irq_tx     = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                if (nonempty) begin
                    pop        = 1'b1;
                    tx_word_d  = fifo_mem[rd_ptr_q];
                    tx_state_d = TxStart;
                    led_d      = 1'b1;
                end
            end
            TxStart: begin
                if (tx_done) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                    led_d      = tx_word_q[0];
                end
            end
            TxData: begin
                if (tx_done) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == BitW'(MSG_WIDTH - 1)) begin
                        tx_state_d = PARITY_EN ? TxParity : TxStop;
                        led_d      = PARITY_EN ? ^tx_word_q : 1'b0;
                    end else begin
                        tx_bit_d = tx_bit_q + BitW'(1);
                        led_d    = tx_word_q[tx_bit_q + BitW'(1)];
                    end
                end
            end
            TxParity: begin
                if (tx_done) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxStop;
                    led_d      = 1'b0;
                end
            end
            TxStop: begin
                if (tx_done) begin
                    irq_tx   = 1'b1;
                    tx_cnt_d = '0;
                    if (nonempty) begin
                        pop        = 1'b1;
                        tx_word_d  = fifo_mem[rd_ptr_q];
                        tx_state_d = TxStart;
                        led_d      = 1'b1;
                    end else begin
                        tx_state_d = TxIdle;
                        led_d      = 1'b0;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // ---------------- RX ----------------
    logic [1:0]           sync_q;
    logic                 rx_line, rx_prev_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [BitW-1:0]      rx_bit_q, rx_bit_d;
    logic [MSG_WIDTH-1:0] rx_shift_q, rx_shift_d, data_q, data_d;
    logic                 rx_par_q, rx_par_d, irq_rx_q, irq_rx_d, rx_err_q, rx_err_d;
    logic                 rx_done, parity_ok;

    assign rx_line   = sync_q[1];
    assign rx_done   = (rx_cnt_q == CntW'(BIT_CLOCKS - 1));
    assign parity_ok = PARITY_EN ? !(^rx_shift_q ^ rx_par_q) : 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            rx_prev_q  <= 1'b0;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            data_q     <= '0;
            irq_rx_q   <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], led_in};
            rx_prev_q  <= rx_line;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            data_q     <= data_d;
            irq_rx_q   <= irq_rx_d;
            rx_err_q   <= rx_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CntW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        data_d     = data_q;
        irq_rx_d   = 1'b0;
        rx_err_d   = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_line && !rx_prev_q) rx_state_d = RxStart;
            end
            RxStart: begin
                // Mid-start-bit sample; a low line here was only a glitch.
                if (rx_cnt_q == CntW'(BIT_CLOCKS / 2 - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_line ? RxData : RxIdle;
                end
            end
            RxData: begin
                if (rx_done) begin
                    rx_cnt_d             = '0;
                    rx_shift_d[rx_bit_q] = rx_line;
                    if (rx_bit_q == BitW'(MSG_WIDTH - 1)) begin
                        rx_state_d = PARITY_EN ? RxParity : RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + BitW'(1);
                    end
                end
            end
            RxParity: begin
                if (rx_done) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_line;
                    rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_done) begin
                    rx_state_d = RxIdle;
                    if (!rx_line && parity_ok) begin
                        data_d   = rx_shift_q;
                        irq_rx_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    assign bus.data_out    = data_q;
    assign bus.irq_tx      = irq_tx;
    assign bus.irq_rx      = irq_rx_q;
    assign bus.rx_error    = rx_err_q;
    assign bus.tx_full     = full;
    assign bus.tx_overflow = overflow_q;
    assign led_out         = led_q;
endmodule

// File: tb/tb_petra_link.sv
// Two cross-coupled petra_link pairs: A->B with defaults, C->D with 12-bit, no-parity, 2-clock bits.
`timescale 1ns/1ps
module tb_petra_link;
    localparam int W     = 8;
    localparam int BC    = 4;
    localparam int DEPTH = 4;
    localparam int F     = (W + 1 + 2) * BC;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    petra_link_if #(.MSG_WIDTH(8))  a_bus ();
    petra_link_if #(.MSG_WIDTH(8))  b_bus ();
    petra_link_if #(.MSG_WIDTH(12)) c_bus ();
    petra_link_if #(.MSG_WIDTH(12)) d_bus ();

    logic a_led_out, b_led_out, b_led_in, c_led_out, d_led_out;
    logic tb_led = 1'b0;
    logic b_sel  = 1'b0;
    assign b_led_in = b_sel ? tb_led : a_led_out;

    petra_link u_a (.clock(clock), .reset(reset), .bus(a_bus), .led_in(b_led_out),
                    .led_out(a_led_out));
    petra_link u_b (.clock(clock), .reset(reset), .bus(b_bus), .led_in(b_led_in),
                    .led_out(b_led_out));
    petra_link #(.MSG_WIDTH(12), .BIT_CLOCKS(2), .FIFO_DEPTH(4), .PARITY_EN(1'b0)) u_c (
        .clock(clock), .reset(reset), .bus(c_bus), .led_in(d_led_out), .led_out(c_led_out));
    petra_link #(.MSG_WIDTH(12), .BIT_CLOCKS(2), .FIFO_DEPTH(4), .PARITY_EN(1'b0)) u_d (
        .clock(clock), .reset(reset), .bus(d_bus), .led_in(c_led_out), .led_out(d_led_out));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each accepted word owns a frame slot; frames run back to back.
    int         cyc = 0;
    int         m_start[$];
    logic [7:0] m_word[$];
    int         last_start = -100000;
    int         s_next;
    logic       m_ovf = 1'b0;
    logic [8:0] rxq[$];  // {is_error, word}
    logic [7:0] m_rx_last = 8'h00;
    logic [8:0] ev;
    int         b_irq_cnt = 0, b_err_cnt = 0, a_irq_tx_cnt = 0;

    function automatic int occ_after(input int t);
        int n = 0;
        foreach (m_start[i]) if (m_start[i] > t) n++;
        return n;
    endfunction

    function automatic logic frame_bit(input logic [7:0] w, input int b);
        if (b == 0) return 1'b1;
        if (b <= W) return w[b-1];
        if (b == W + 1) return ^w;
        return 1'b0;
    endfunction

    function automatic logic exp_led(input int t);
        foreach (m_start[i])
            if (t >= m_start[i] && t < m_start[i] + F)
                return frame_bit(m_word[i], (t - m_start[i]) / BC);
        return 1'b0;
    endfunction

    function automatic logic exp_irq_tx(input int t);
        foreach (m_start[i]) if (t == m_start[i] + F - 1) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_start.delete();
            m_word.delete();
            rxq.delete();
            m_ovf      = 1'b0;
            m_rx_last  = 8'h00;
            last_start = -100000;
        end else begin
            cyc++;
            if (a_bus.send_message) begin
                if (occ_after(cyc - 1) < DEPTH) begin
                    s_next = (cyc + 1 > last_start + F) ? cyc + 1 : last_start + F;
                    m_start.push_back(s_next);
                    m_word.push_back(a_bus.data_in);
                    rxq.push_back({1'b0, a_bus.data_in});
                    last_start = s_next;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("a_led_out", a_led_out, exp_led(cyc));
        check("a_irq_tx", a_bus.irq_tx, exp_irq_tx(cyc));
        check("a_tx_full", a_bus.tx_full, occ_after(cyc) == DEPTH);
        check("a_tx_overflow", a_bus.tx_overflow, m_ovf);
        if (a_bus.irq_tx) a_irq_tx_cnt++;
        if (b_bus.irq_rx || b_bus.rx_error) begin
            if (b_bus.irq_rx) b_irq_cnt++;
            if (b_bus.rx_error) b_err_cnt++;
            check("b_rx_exclusive", b_bus.irq_rx && b_bus.rx_error, 1'b0);
            check("b_rx_expected", rxq.size() > 0, 1'b1);
            if (rxq.size() > 0) begin
                ev = rxq.pop_front();
                check("b_rx_kind", b_bus.rx_error, ev[8]);
                if (!ev[8]) m_rx_last = ev[7:0];
            end
        end
        check("b_data_out", b_bus.data_out, m_rx_last);
        check("quiet_lines", {a_bus.irq_rx, a_bus.rx_error, b_bus.irq_tx, b_led_out,
                              b_bus.tx_overflow}, 5'b0);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_rx_drain(input string name, input int budget);
        int k = 0;
        while (rxq.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check(name, rxq.size(), 0);
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            tb_led = bits[i];
            repeat (BC) tick();
        end
        tb_led = 1'b0;
    endtask

    int         k, i0, e0;
    logic [15:0] bad_bits;

    initial begin
        reset = 1'b1;
        a_bus.send_message = 1'b0; a_bus.data_in = '0;
        b_bus.send_message = 1'b0; b_bus.data_in = '0;
        c_bus.send_message = 1'b0; c_bus.data_in = '0;
        d_bus.send_message = 1'b0; d_bus.data_in = '0;
        repeat (3) tick();
        check("rst_a_led_out", a_led_out, 1'b0);
        check("rst_b_data_out", b_bus.data_out, 8'h00);
        check("rst_a_tx_full", a_bus.tx_full, 1'b0);
        check("rst_a_irq_tx", a_bus.irq_tx, 1'b0);
        reset = 1'b0;
        repeat (2) tick();

        // Single word 8'h50
        a_bus.data_in = 8'h50; a_bus.send_message = 1'b1;
        tick();
        a_bus.send_message = 1'b0;
        check("a_led_before_start", a_led_out, 1'b0);
        tick();
        check("a_led_latency", a_led_out, 1'b1);
        k = 1;
        while (!a_bus.irq_tx && k < 100) begin tick(); k++; end
        check("a_irq_tx_cycle", k, 44);
        wait_rx_drain("b_rx_50_arrived", 100);
        check("b_data_50", b_bus.data_out, 8'h50);
        check("b_no_err_50", b_err_cnt, 0);

        // Six back-to-back writes; the sixth hits a full FIFO
        i0 = b_irq_cnt;
        for (int i = 1; i <= 6; i++) begin
            a_bus.data_in = 8'(i); a_bus.send_message = 1'b1;
            tick();
            if (i == 5) check("a_full_after_5", a_bus.tx_full, 1'b1);
        end
        a_bus.send_message = 1'b0;
        check("a_overflow_sticky", a_bus.tx_overflow, 1'b1);
        wait_rx_drain("b_rx_burst_arrived", 6 * F + 100);
        check("b_burst_irq_count", b_irq_cnt - i0, 5);
        check("b_data_05", b_bus.data_out, 8'h05);

        // Bench-driven 8'hA5 frame with wrong parity bit 1
        b_sel = 1'b1;
        e0 = b_err_cnt; i0 = b_irq_cnt;
        rxq.push_back({1'b1, 8'h00});
        bad_bits = {5'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
        drive_bits(bad_bits, 11);
        wait_rx_drain("b_bad_frame_seen", 50);
        check("b_bad_err_count", b_err_cnt - e0, 1);
        check("b_bad_no_irq", b_irq_cnt - i0, 0);
        check("b_data_held", b_bus.data_out, 8'h05);

        // One-cycle glitch on B.led_in
        e0 = b_err_cnt; i0 = b_irq_cnt;
        tb_led = 1'b1;
        tick();
        tb_led = 1'b0;
        repeat (40) tick();
        check("glitch_no_irq", b_irq_cnt - i0, 0);
        check("glitch_no_err", b_err_cnt - e0, 0);
        b_sel = 1'b0;
        tick();

        // Reset 20 cycles into a frame of 8'h3C
        a_bus.data_in = 8'h3C; a_bus.send_message = 1'b1;
        tick();
        a_bus.send_message = 1'b0;
        k = 0;
        while (!a_led_out && k < 10) begin tick(); k++; end
        check("a_led_rise_3c", a_led_out, 1'b1);
        repeat (19) tick();
        i0 = a_irq_tx_cnt;
        reset = 1'b1;
        #1;
        check("rst_mid_led_out", a_led_out, 1'b0);
        check("rst_mid_data_out", b_bus.data_out, 8'h00);
        repeat (3) tick();
        reset = 1'b0;
        repeat (F + 10) tick();
        check("rst_no_irq_tx", a_irq_tx_cnt - i0, 0);
        a_bus.data_in = 8'h3C; a_bus.send_message = 1'b1;
        tick();
        a_bus.send_message = 1'b0;
        wait_rx_drain("b_rx_3c_arrived", 100);
        check("b_data_3c", b_bus.data_out, 8'h3C);

        // 12-bit, no parity, 2 clocks per bit: frame is 28 cycles
        c_bus.data_in = 12'hABC; c_bus.send_message = 1'b1;
        tick();
        c_bus.send_message = 1'b0;
        k = 0;
        while (!c_led_out && k < 10) begin tick(); k++; end
        check("c_led_rise", c_led_out, 1'b1);
        k = 1;
        while (!c_bus.irq_tx && k < 100) begin tick(); k++; end
        check("c_irq_tx_cycle", k, 28);
        k = 0;
        while (!d_bus.irq_rx && !d_bus.rx_error && k < 100) begin tick(); k++; end
        check("d_irq_rx_seen", d_bus.irq_rx, 1'b1);
        check("d_no_rx_error", d_bus.rx_error, 1'b0);
        check("d_data_abc", d_bus.data_out, 12'hABC);

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
